// File: rtl/epp_regbus.sv
// -----------------------------------------------------------------------------
// epp_regbus
// Bridges an asynchronous EPP (Enhanced Parallel Port) host to a simple
// word-wide register bus. The host issues address cycles (Astb) and data
// cycles (Dstb). BYTES data bytes are gathered into one IP word, sent
// least-significant byte first, and then written with a single ip_wr pulse.
// A read fetches a whole word with one ip_rd pulse and then returns it a byte
// at a time.
//
// Handshake: Wait is 1 whenever the FSM is not IDLE. The host lowers a strobe,
// waits for Wait=1, samples or holds Db, and then raises the strobe. The FSM
// returns to IDLE, which drops Wait, only after it sees the strobe high again.
// On the IP side, ip_wr or ip_rd is a one-cycle pulse. The IP answers with
// ip_do_rdy=1 on any later cycle. If it does not answer within TIMEOUT
// cycles, the sticky timeout flag is set and the transfer completes anyway.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   Db_unsync      8-bit bidirectional EPP data bus
//   Astb_unsync    address strobe (active low, async)
//   Dstb_unsync    data strobe (active low, async)
//   Wr_unsync      0 = host write (async)
//   Wait           strobe response
//   ip_addr        register address
//   ip_do          assembled write word
//   ip_di          read word from the IP
//   ip_do_rdy      IP completion acknowledge
//   ip_wr, ip_rd   one-cycle write/read pulses
//   timeout        sticky IP-timeout flag, cleared by an address write
// -----------------------------------------------------------------------------
module epp_regbus #(
   parameter int BYTES   = 2,
   parameter int AUTOINC = 1,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   inout  wire  [7:0]         Db_unsync,
   input  logic               Astb_unsync,
   input  logic               Dstb_unsync,
   input  logic               Wr_unsync,
   output logic               Wait,
   output logic [7:0]         ip_addr,
   output logic [8*BYTES-1:0] ip_do,
   input  logic [8*BYTES-1:0] ip_di,
   input  logic               ip_do_rdy,
   output logic               ip_wr,
   output logic               ip_rd,
   output logic               timeout
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ADDR_END = 3'd1,
      WR_ACK   = 3'd2,
      RD_ACK   = 3'd3,
      DATA_END = 3'd4
   } state_t;

   localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);
   localparam logic [1:0]  LANE_LAST = 2'(BYTES - 1);

   state_t               state, state_d;
   logic                 astb_s1, astb_s2, dstb_s1, dstb_s2, wr_s1, wr_s2;
   logic [7:0]           db_s1, db_s2;
   logic [1:0]           lane;
   logic [15:0]          ack_cnt;
   logic [8*BYTES-1:0]   rd_buf;
   logic [7:0]           rd_byte;
   logic [7:0]           db_out;
   logic                 db_oe;
   logic                 word_done;   // DATA_END is closing the last byte of a word
   logic                 last_lane;

   // single-cycle events decoded by the FSM and consumed by the datapath
   logic ev_addr_wr, ev_addr_rd, ev_data_wr, ev_rd_start, ev_rd_byte;
   logic ev_ack, ev_to, ev_release;

   assign Db_unsync = db_oe ? db_out : 8'bz;
   assign Wait      = (state != IDLE);
   assign last_lane = (lane == LANE_LAST);

   // Two-flop synchronisers. Strobes idle high, so they reset to 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         astb_s1 <= 1'b1; astb_s2 <= 1'b1;
         dstb_s1 <= 1'b1; dstb_s2 <= 1'b1;
         wr_s1   <= 1'b1; wr_s2   <= 1'b1;
         db_s1   <= 8'h00; db_s2  <= 8'h00;
      end else begin
         astb_s1 <= Astb_unsync; astb_s2 <= astb_s1;
         dstb_s1 <= Dstb_unsync; dstb_s2 <= dstb_s1;
         wr_s1   <= Wr_unsync;   wr_s2   <= wr_s1;
         db_s1   <= Db_unsync;   db_s2   <= db_s1;
      end
   end

   // Select the byte of the read buffer addressed by the current lane.
   always_comb begin
      rd_byte = 8'h00;
      for (int b = 0; b < BYTES; b++)
         if (lane == 2'(b)) rd_byte = rd_buf[b*8 +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d     = state;
      ev_addr_wr  = 1'b0;
      ev_addr_rd  = 1'b0;
      ev_data_wr  = 1'b0;
      ev_rd_start = 1'b0;
      ev_rd_byte  = 1'b0;
      ev_ack      = 1'b0;
      ev_to       = 1'b0;
      ev_release  = 1'b0;
      case (state)
         IDLE: begin
            // When both strobes are low, the address strobe is checked first.
            if (!astb_s2) begin
               state_d = ADDR_END;
               if (!wr_s2) ev_addr_wr = 1'b1;
               else        ev_addr_rd = 1'b1;
            end else if (!dstb_s2) begin
               if (!wr_s2) begin
                  ev_data_wr = 1'b1;
                  state_d    = last_lane ? WR_ACK : DATA_END;
               end else if (lane == 2'd0) begin
                  ev_rd_start = 1'b1;
                  state_d     = RD_ACK;
               end else begin
                  ev_rd_byte = 1'b1;
                  state_d    = DATA_END;
               end
            end
         end
         ADDR_END: begin
            if (astb_s2) begin
               state_d    = IDLE;
               ev_release = 1'b1;
            end
         end
         WR_ACK, RD_ACK: begin
            // ip_wr/ip_rd is high only on the first ACK cycle, so ip_do_rdy
            // is ignored while the pulse is still out.
            if (!(ip_wr || ip_rd) && ip_do_rdy) ev_ack = 1'b1;
            else if (ack_cnt == TO_LAST)        ev_to  = 1'b1;
            if (ev_ack || ev_to) state_d = DATA_END;
         end
         DATA_END: begin
            if (dstb_s2) begin
               state_d    = IDLE;
               ev_release = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ip_wr     <= 1'b0;
         ip_rd     <= 1'b0;
         ip_addr   <= 8'h00;
         ip_do     <= '0;
         rd_buf    <= '0;
         lane      <= 2'd0;
         timeout   <= 1'b0;
         ack_cnt   <= 16'd0;
         db_out    <= 8'h00;
         db_oe     <= 1'b0;
         word_done <= 1'b0;
      end else begin
         ip_wr <= ev_data_wr && last_lane;
         ip_rd <= ev_rd_start;

         if (state == WR_ACK || state == RD_ACK) ack_cnt <= ack_cnt + 16'd1;
         else                                    ack_cnt <= 16'd0;

         if (ev_addr_wr) begin
            ip_addr <= db_s2;
            lane    <= 2'd0;
            timeout <= 1'b0;
         end

         if (ev_addr_rd) begin
            db_out <= ip_addr;
            db_oe  <= 1'b1;
         end

         if (ev_data_wr) begin
            for (int b = 0; b < BYTES; b++)
               if (lane == 2'(b)) ip_do[b*8 +: 8] <= db_s2;
            if (!last_lane) lane <= lane + 2'd1;
         end

         if (ev_rd_byte) begin
            db_out    <= rd_byte;
            db_oe     <= 1'b1;
            lane      <= last_lane ? 2'd0 : lane + 2'd1;
            word_done <= last_lane;
         end

         if (ev_ack || ev_to) begin
            if (state == RD_ACK) begin
               // A timed-out read returns all-ones in every byte.
               rd_buf    <= ev_ack ? ip_di : '1;
               db_out    <= ev_ack ? ip_di[7:0] : 8'hFF;
               db_oe     <= 1'b1;
               lane      <= (BYTES == 1) ? 2'd0 : 2'd1;
               word_done <= (BYTES == 1);
            end else begin
               lane      <= 2'd0;
               word_done <= 1'b1;
            end
            if (ev_to) timeout <= 1'b1;
         end

         if (ev_release) begin
            db_oe <= 1'b0;
            if (state == DATA_END) begin
               word_done <= 1'b0;
               if (word_done && AUTOINC != 0) ip_addr <= ip_addr + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_epp_regbus.sv
// -----------------------------------------------------------------------------
// tb_epp_regbus
// Directed bench for epp_regbus with BYTES=2, AUTOINC=1 and TIMEOUT=8.
// Host tasks run EPP address and data cycles. A monitor counts the IP
// pulses and captures ip_addr/ip_do at each write pulse. Every expected
// value in this file was worked out by hand.
// -----------------------------------------------------------------------------
module tb_epp_regbus;

   logic        clk = 1'b0;
   logic        rst;
   wire  [7:0]  db;
   logic [7:0]  host_db;
   logic        host_drv;
   logic        astb, dstb, wr;
   logic        wait_o;
   logic [7:0]  ip_addr;
   logic [15:0] ip_do;
   logic [15:0] ip_di;
   logic        ip_do_rdy;
   logic        ip_wr, ip_rd, timeout;

   int          checks = 0;
   int          errors = 0;
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   logic [7:0]  wr_addr;
   logic [15:0] wr_do;
   logic [7:0]  rd_val;
   int          rd_base;

   assign db = host_drv ? host_db : 8'bz;

   epp_regbus #(.BYTES(2), .AUTOINC(1), .TIMEOUT(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .Db_unsync   (db),
      .Astb_unsync (astb),
      .Dstb_unsync (dstb),
      .Wr_unsync   (wr),
      .Wait        (wait_o),
      .ip_addr     (ip_addr),
      .ip_do       (ip_do),
      .ip_di       (ip_di),
      .ip_do_rdy   (ip_do_rdy),
      .ip_wr       (ip_wr),
      .ip_rd       (ip_rd),
      .timeout     (timeout)
   );

   // clock
   always #5 clk = ~clk;

   // Pulse monitor. A pulse two cycles wide is counted twice.
   always @(negedge clk) begin
      if (ip_wr) begin
         wr_cnt  = wr_cnt + 1;
         wr_addr = ip_addr;
         wr_do   = ip_do;
      end
      if (ip_rd) rd_cnt = rd_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bounded wait for Wait to reach a level. An expired bound counts as a failure.
   task automatic wait_for_wait(input logic v, input string tag);
      int n = 0;
      while (wait_o !== v && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(wait_o), 32'(v));
   endtask

   task automatic addr_write(input logic [7:0] a);
      @(negedge clk);
      host_drv = 1'b1; host_db = a; wr = 1'b0;
      @(negedge clk);
      astb = 1'b0;
      wait_for_wait(1'b1, "aw_wait_hi");
      astb = 1'b1;
      wait_for_wait(1'b0, "aw_wait_lo");
      host_drv = 1'b0; wr = 1'b1;
   endtask

   task automatic addr_read(output logic [7:0] d);
      @(negedge clk);
      host_drv = 1'b0; wr = 1'b1;
      astb = 1'b0;
      wait_for_wait(1'b1, "ar_wait_hi");
      repeat (3) @(negedge clk);
      d = db;
      astb = 1'b1;
      wait_for_wait(1'b0, "ar_wait_lo");
   endtask

   task automatic data_write(input logic [7:0] d);
      @(negedge clk);
      host_drv = 1'b1; host_db = d; wr = 1'b0;
      @(negedge clk);
      dstb = 1'b0;
      wait_for_wait(1'b1, "dw_wait_hi");
      dstb = 1'b1;
      wait_for_wait(1'b0, "dw_wait_lo");
      host_drv = 1'b0; wr = 1'b1;
   endtask

   // Long enough for a full TIMEOUT=8 acknowledge before Db is sampled.
   task automatic data_read(output logic [7:0] d);
      @(negedge clk);
      host_drv = 1'b0; wr = 1'b1;
      dstb = 1'b0;
      wait_for_wait(1'b1, "dr_wait_hi");
      repeat (15) @(negedge clk);
      d = db;
      dstb = 1'b1;
      wait_for_wait(1'b0, "dr_wait_lo");
   endtask

   initial begin
      // reset
      rst = 1'b1; astb = 1'b1; dstb = 1'b1; wr = 1'b1;
      host_drv = 1'b0; host_db = 8'h00; ip_di = 16'h0000; ip_do_rdy = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_wait",  32'(wait_o),  32'd0);
      check("rst_addr",  32'(ip_addr), 32'h00);
      check("rst_do",    32'(ip_do),   32'h0000);
      check("rst_wr",    32'(ip_wr),   32'd0);
      check("rst_rd",    32'(ip_rd),   32'd0);
      check("rst_to",    32'(timeout), 32'd0);
      check("rst_db_oe", 32'(dut.db_oe), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Two-byte word write: one pulse, then the address auto-increments.
      addr_write(8'h10);
      check("aw_addr", 32'(ip_addr), 32'h10);
      data_write(8'h34);
      check("w1_no_pulse", 32'(wr_cnt), 32'd0);
      check("w1_do",       32'(ip_do),  32'h0034);
      check("w1_addr",     32'(ip_addr), 32'h10);
      data_write(8'h12);
      check("w2_pulses",   32'(wr_cnt),  32'd1);
      check("w2_do_pulse", 32'(wr_do),   32'h1234);
      check("w2_addr_pulse", 32'(wr_addr), 32'h10);
      check("w2_addr_after", 32'(ip_addr), 32'h11);

      // Two-byte word read: one ip_rd pulse, low byte returned first.
      ip_di = 16'hBEEF;
      data_read(rd_val);
      check("r1_byte",  32'(rd_val),  32'hEF);
      check("r1_pulse", 32'(rd_cnt),  32'd1);
      check("r1_addr",  32'(ip_addr), 32'h11);
      data_read(rd_val);
      check("r2_byte",  32'(rd_val),  32'hBE);
      check("r2_pulse", 32'(rd_cnt),  32'd1);
      check("r2_addr",  32'(ip_addr), 32'h12);

      // The IP never acknowledges: the read times out and returns 0xFF bytes.
      ip_do_rdy = 1'b0;
      data_read(rd_val);
      check("to1_byte", 32'(rd_val),  32'hFF);
      check("to1_flag", 32'(timeout), 32'd1);
      check("to1_pulse", 32'(rd_cnt), 32'd2);
      data_read(rd_val);
      check("to2_byte", 32'(rd_val),  32'hFF);
      check("to2_pulse", 32'(rd_cnt), 32'd2);
      check("to2_addr", 32'(ip_addr), 32'h13);
      ip_do_rdy = 1'b1;

      // The address wraps from 0xFF to 0x00 after a full word write.
      addr_write(8'hFF);
      check("wrap_to_clr", 32'(timeout), 32'd0);
      data_write(8'h01);
      data_write(8'h02);
      check("wrap_pulses",  32'(wr_cnt),  32'd2);
      check("wrap_do",      32'(wr_do),   32'h0201);
      check("wrap_addr_at", 32'(wr_addr), 32'hFF);
      check("wrap_addr",    32'(ip_addr), 32'h00);
      addr_read(rd_val);
      check("wrap_ar", 32'(rd_val), 32'h00);

      // Both strobes low together with Wr=0: only the address cycle is taken.
      @(negedge clk);
      host_drv = 1'b1; host_db = 8'h22; wr = 1'b0;
      @(negedge clk);
      astb = 1'b0; dstb = 1'b0;
      wait_for_wait(1'b1, "both_wait_hi");
      astb = 1'b1; dstb = 1'b1;
      wait_for_wait(1'b0, "both_wait_lo");
      host_drv = 1'b0; wr = 1'b1;
      repeat (4) @(negedge clk);
      check("both_addr",   32'(ip_addr), 32'h22);
      check("both_no_wr",  32'(wr_cnt),  32'd2);
      check("both_do",     32'(ip_do),   32'h0201);

      // Reset in RD_ACK aborts the read with no further pulse.
      ip_do_rdy = 1'b0;
      rd_base = rd_cnt;
      @(negedge clk);
      wr = 1'b1; dstb = 1'b0;
      wait_for_wait(1'b1, "ra_wait_hi");
      repeat (2) @(negedge clk);
      check("ra_pulse", 32'(rd_cnt), 32'(rd_base + 1));
      rst = 1'b1; dstb = 1'b1;
      @(negedge clk);
      check("ra_wait",  32'(wait_o),      32'd0);
      check("ra_db_oe", 32'(dut.db_oe),   32'd0);
      check("ra_addr",  32'(ip_addr),     32'h00);
      check("ra_rd",    32'(ip_rd),       32'd0);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("ra_no_pulse", 32'(rd_cnt), 32'(rd_base + 1));
      check("ra_idle",     32'(wait_o), 32'd0);
      check("ra_addr_hold", 32'(ip_addr), 32'h00);

      // A fresh read after reset pulses ip_rd again.
      ip_do_rdy = 1'b1;
      ip_di = 16'hA55A;
      data_read(rd_val);
      check("fr1_byte",  32'(rd_val), 32'h5A);
      check("fr1_pulse", 32'(rd_cnt), 32'(rd_base + 2));
      data_read(rd_val);
      check("fr2_byte",  32'(rd_val),  32'hA5);
      check("fr2_addr",  32'(ip_addr), 32'h01);
      check("fr2_to",    32'(timeout), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
